// File: rtl/msi_pkg.sv
// Shared encodings for the MSI bus controller: cache states, bus ops and FSM states.
package msi_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } cache_state_e;

  typedef logic [1:0] bus_op_t;

  localparam bus_op_t OP_NONE   = 2'b00;
  localparam bus_op_t OP_RDMISS = 2'b01;
  localparam bus_op_t OP_WRMISS = 2'b10;
  localparam bus_op_t OP_INV    = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_VICTIM_WB = 3'd1;
  localparam logic [2:0] ST_BCAST     = 3'd2;
  localparam logic [2:0] ST_SNOOP     = 3'd3;
  localparam logic [2:0] ST_OWNER_WB  = 3'd4;
  localparam logic [2:0] ST_FILL      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // True when two or more bits are set; callers zero-extend to 8 bits.
  function automatic logic more_than_one(input logic [7:0] v);
    return |(v & (v - 8'd1));
  endfunction

endpackage

// File: rtl/msi_bus_controller_rr_arbiter.sv
// Combinational round-robin arbiter: first valid index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CPU = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_CPU-1:0] valid,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_CPU-1:0] grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_CPU; k++) begin
      cand = (int'(ptr) + k) % N_CPU;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/msi_bus_controller.sv
// Snooping-bus controller: grants MSI requesters round-robin, broadcasts, sequences
// victim/owner write-backs and the memory fill, then acks the requester.
//   state     | meaning
//   IDLE      | waiting for a valid request; arbitrate and latch transaction
//   VICTIM_WB | requester's own modified victim written to memory
//   BCAST     | one-cycle snoop broadcast
//   SNOOP     | sample snoop_wb (requester's bit masked)
//   OWNER_WB  | modified owner written back to memory
//   FILL      | memory read of the block
//   DONE      | one-cycle ack to the requester
module msi_bus_controller
  import msi_pkg::*;
#(
  parameter int N_CPU  = 4,
  parameter int ADDR_W = 8,
  parameter int SRC_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CPU-1:0]        req,
  input  logic [2*N_CPU-1:0]      req_op,
  input  logic [N_CPU-1:0]        req_wb,
  input  logic [N_CPU*ADDR_W-1:0] req_addr,
  output logic [N_CPU-1:0]        ack,
  output logic                    bus_valid,
  output logic [1:0]              bus_op,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [SRC_W-1:0]        bus_src,
  input  logic [N_CPU-1:0]        snoop_wb,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    err
);

  logic [2:0]        state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [SRC_W-1:0]  src_q, src_d;
  bus_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [N_CPU-1:0]  valid;
  logic [N_CPU-1:0]  arb_grant;
  logic [SRC_W-1:0]  arb_idx;
  logic              arb_any;
  logic [N_CPU-1:0]  src_onehot;
  logic [N_CPU-1:0]  snoop_m;

  always_comb begin
    valid = '0;
    for (int i = 0; i < N_CPU; i++) begin
      valid[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
    end
  end

  rr_arbiter #(
    .N_CPU (N_CPU),
    .SRC_W (SRC_W)
  ) u_arb (
    .valid (valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign src_onehot = N_CPU'(1) << src_q;
  assign snoop_m    = snoop_wb & ~src_onehot;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          src_d  = arb_idx;
          op_d   = req_op[2*int'(arb_idx) +: 2];
          addr_d = req_addr[ADDR_W*int'(arb_idx) +: ADDR_W];
          ptr_d  = (arb_idx == SRC_W'(N_CPU-1)) ? '0 : arb_idx + SRC_W'(1);
          state_d = (|(req_wb & arb_grant)) ? ST_VICTIM_WB : ST_BCAST;
        end
      end
      ST_VICTIM_WB: if (mem_ready) state_d = ST_BCAST;
      ST_BCAST:     state_d = ST_SNOOP;
      ST_SNOOP: begin
        if (|snoop_m) begin
          state_d = ST_OWNER_WB;
          // Multiple owners or an owner on invalidate is a protocol violation; still serviced.
          if (more_than_one(8'(snoop_m)) || op_q == OP_INV) err_d = 1'b1;
        end else if (op_q == OP_INV) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_OWNER_WB: if (mem_ready) state_d = (op_q == OP_INV) ? ST_DONE : ST_FILL;
      ST_FILL:     if (mem_ready) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // All outputs decode from registered state only.
  assign ack       = (state_q == ST_DONE) ? src_onehot : '0;
  assign bus_valid = (state_q == ST_BCAST);
  assign bus_op    = bus_valid ? op_q : OP_NONE;
  assign bus_addr  = bus_valid ? addr_q : '0;
  assign bus_src   = bus_valid ? src_q : '0;
  assign mem_req   = (state_q == ST_VICTIM_WB) || (state_q == ST_OWNER_WB) || (state_q == ST_FILL);
  assign mem_we    = (state_q == ST_VICTIM_WB) || (state_q == ST_OWNER_WB);
  assign mem_addr  = mem_req ? addr_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_msi_bus_controller.sv
// Directed self-checking bench for msi_bus_controller (N_CPU=4, ADDR_W=8, SRC_W=2).
module tb_msi_bus_controller;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [3:0]  req_wb;
  logic [31:0] req_addr;
  logic [3:0]  ack;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [7:0]  bus_addr;
  logic [1:0]  bus_src;
  logic [3:0]  snoop_wb;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic        mem_ready;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  msi_bus_controller #(.N_CPU(4), .ADDR_W(8), .SRC_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_wb    (req_wb),
    .req_addr  (req_addr),
    .ack       (ack),
    .bus_valid (bus_valid),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_src   (bus_src),
    .snoop_wb  (snoop_wb),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input int i, input logic [1:0] op, input logic [7:0] addr, input logic wb);
    req_op[2*i +: 2]   = op;
    req_addr[8*i +: 8] = addr;
    req_wb[i]          = wb;
    req[i]             = 1'b1;
  endtask

  task automatic drop_all();
    req    = '0;
    req_op = '0;
    req_wb = '0;
  endtask

  initial begin
    int exp_order [5];
    int cnt [4];
    int n_ack;
    int idx;

    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; req_op = '0; req_wb = '0; req_addr = '0;
    snoop_wb = '0; mem_ready = 1'b0;
    step(); step();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // Invalidate from CPU1, no owner: ack at cycle 3, no memory traffic.
    set_cpu(1, 2'b11, 8'h2A, 1'b0);
    chk("inv_c0_busy", 32'(busy), 0);
    step();
    chk("inv_c1_bus_valid", 32'(bus_valid), 1);
    chk("inv_c1_bus_op", 32'(bus_op), 3);
    chk("inv_c1_bus_addr", 32'(bus_addr), 32'h2A);
    chk("inv_c1_bus_src", 32'(bus_src), 1);
    chk("inv_c1_mem_req", 32'(mem_req), 0);
    req_addr[15:8] = 8'h55;
    step();
    chk("inv_c2_bus_valid", 32'(bus_valid), 0);
    chk("inv_c2_busy", 32'(busy), 1);
    chk("inv_c2_mem_req", 32'(mem_req), 0);
    step();
    chk("inv_c3_ack", 32'(ack), 4'b0010);
    chk("inv_c3_mem_req", 32'(mem_req), 0);
    drop_all();
    step();
    chk("inv_c4_ack", 32'(ack), 0);
    chk("inv_c4_busy", 32'(busy), 0);

    // Read miss from CPU0 with CPU3 owning the block; pointer wraps from 2 to 0.
    mem_ready = 1'b1;
    set_cpu(0, 2'b01, 8'h10, 1'b0);
    step();
    chk("own_c1_bus_valid", 32'(bus_valid), 1);
    chk("own_c1_bus_src", 32'(bus_src), 0);
    chk("own_c1_bus_op", 32'(bus_op), 1);
    step();
    chk("own_c2_mem_req", 32'(mem_req), 0);
    snoop_wb = 4'b1000;
    step();
    snoop_wb = '0;
    chk("own_c3_mem_req", 32'(mem_req), 1);
    chk("own_c3_mem_we", 32'(mem_we), 1);
    chk("own_c3_mem_addr", 32'(mem_addr), 32'h10);
    step();
    chk("own_c4_mem_req", 32'(mem_req), 1);
    chk("own_c4_mem_we", 32'(mem_we), 0);
    chk("own_c4_mem_addr", 32'(mem_addr), 32'h10);
    step();
    chk("own_c5_ack", 32'(ack), 4'b0001);
    chk("own_c5_err", 32'(err), 0);
    drop_all();
    step();

    // Write miss from CPU2 with victim write-back; memory answers after 3 wait cycles.
    mem_ready = 1'b0;
    set_cpu(2, 2'b10, 8'h33, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vic_wb%0d_mem_req", k), 32'(mem_req), 1);
      chk($sformatf("vic_wb%0d_mem_we", k), 32'(mem_we), 1);
      chk($sformatf("vic_wb%0d_mem_addr", k), 32'(mem_addr), 32'h33);
      chk($sformatf("vic_wb%0d_bus_valid", k), 32'(bus_valid), 0);
      mem_ready = (k == 3);
      step();
    end
    mem_ready = 1'b0;
    chk("vic_bcast_valid", 32'(bus_valid), 1);
    chk("vic_bcast_src", 32'(bus_src), 2);
    chk("vic_bcast_op", 32'(bus_op), 2);
    chk("vic_bcast_mem_req", 32'(mem_req), 0);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vic_fill%0d_mem_req", k), 32'(mem_req), 1);
      chk($sformatf("vic_fill%0d_mem_we", k), 32'(mem_we), 0);
      chk($sformatf("vic_fill%0d_ack", k), 32'(ack), 0);
      mem_ready = (k == 3);
      step();
    end
    mem_ready = 1'b0;
    chk("vic_ack", 32'(ack), 4'b0100);
    drop_all();
    step();

    // Reset while CPU3's fill is outstanding: discarded, no ack.
    set_cpu(3, 2'b01, 8'h44, 1'b0);
    step();
    chk("rmid_bus_src", 32'(bus_src), 3);
    step();
    step();
    chk("rmid_fill_mem_req", 32'(mem_req), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drop_all();
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_mem_req", 32'(mem_req), 0);
    chk("rmid_mem_addr", 32'(mem_addr), 0);
    chk("rmid_ack", 32'(ack), 0);
    step();
    chk("rmid_ack2", 32'(ack), 0);
    chk("rmid_busy2", 32'(busy), 0);

    // Round robin: all four request, drop on ack, re-raise one cycle later.
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cpu(i, 2'b01, 8'(8'h80 + i), 1'b0);
      cnt[i] = 0;
    end
    n_ack = 0;
    for (int cyc = 0; cyc < 200 && n_ack < 5; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) req[i] = 1'b1;
        end
      end
      if (ack != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        chk($sformatf("rr_onehot%0d", n_ack), 32'($onehot(ack)), 1);
        chk($sformatf("rr_grant%0d", n_ack), 32'(idx), 32'(exp_order[n_ack]));
        req[idx] = 1'b0;
        cnt[idx] = 2;
        n_ack++;
        if (n_ack == 5) drop_all();
      end
      step();
    end
    chk("rr_ack_count", 32'(n_ack), 5);
    drop_all();
    for (int cyc = 0; cyc < 20 && busy; cyc++) step();
    chk("rr_idle", 32'(busy), 0);

    // Requester's own snoop bit is masked: plain fill, no error.
    set_cpu(0, 2'b01, 8'h20, 1'b0);
    step();
    step();
    snoop_wb = 4'b0001;
    step();
    snoop_wb = '0;
    chk("self_mem_req", 32'(mem_req), 1);
    chk("self_mem_we", 32'(mem_we), 0);
    chk("self_err", 32'(err), 0);
    step();
    chk("self_ack", 32'(ack), 4'b0001);
    drop_all();
    step();

    // Two owners: error raised, single owner write-back, then fill.
    set_cpu(0, 2'b01, 8'h21, 1'b0);
    step();
    step();
    chk("multi_err_before", 32'(err), 0);
    snoop_wb = 4'b0110;
    step();
    snoop_wb = '0;
    chk("multi_err", 32'(err), 1);
    chk("multi_owner_we", 32'(mem_we), 1);
    chk("multi_owner_addr", 32'(mem_addr), 32'h21);
    step();
    chk("multi_fill_we", 32'(mem_we), 0);
    chk("multi_fill_req", 32'(mem_req), 1);
    step();
    chk("multi_ack", 32'(ack), 4'b0001);
    drop_all();
    step();
    chk("multi_err_sticky", 32'(err), 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err_cleared", 32'(err), 0);

    // Invalidate that finds an owner: error, owner write-back, then straight to ack.
    set_cpu(2, 2'b11, 8'h5C, 1'b0);
    step();
    chk("invown_bus_src", 32'(bus_src), 2);
    step();
    snoop_wb = 4'b0010;
    step();
    snoop_wb = '0;
    chk("invown_err", 32'(err), 1);
    chk("invown_we", 32'(mem_we), 1);
    chk("invown_addr", 32'(mem_addr), 32'h5C);
    step();
    chk("invown_ack", 32'(ack), 4'b0100);
    chk("invown_mem_req", 32'(mem_req), 0);
    drop_all();
    step();
    chk("invown_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msi_bus_controller.md
Name: msi_bus_controller

Overview:
- Shared snooping-bus controller for the MSI cache system.
- Collects the readMiss / writeMiss / invalidate / writeBack requests from N per-CPU MSI controllers and grants the bus round-robin.
- For each granted transaction: broadcasts it for snooping, sequences owner and victim write-backs and the memory fill, then acknowledges the requester.
- Sits between the per-CPU MSI state machines, the snoop-side logic and main memory.

Parameters:
N_CPU, 4, number of requesting caches (2..8)
ADDR_W, 8, block address width
SRC_W, 2, width of requester index; must be at least clog2(N_CPU)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
req  in  N_CPU  per-CPU bus request; held high until ack
req_op  in  2*N_CPU  per-CPU op, CPU i at bits [2i+1:2i]: 01 readMiss, 10 writeMiss, 11 invalidate, 00 = no request
req_wb  in  N_CPU  requester's own Modified victim must be written back first
req_addr  in  N_CPU*ADDR_W  per-CPU block address
ack  out  N_CPU  one-cycle completion pulse to the granted CPU
bus_valid  out  1  snoop broadcast strobe, one cycle
bus_op  out  2  broadcast op (same codes as req_op)
bus_addr  out  ADDR_W  broadcast address
bus_src  out  SRC_W  index of the granted CPU
snoop_wb  in  N_CPU  snoop response: CPU holds the block Modified and must write it back; sampled in SNOOP
mem_req  out  1  memory access strobe, held until mem_ready
mem_we  out  1  1 = write-back, 0 = fill read
mem_addr  out  ADDR_W  memory block address
mem_ready  in  1  memory completes the access this cycle
busy  out  1  high in every state except IDLE
err  out  1  sticky protocol-error flag

Behaviour:
- Reset, on the clock edge with reset high: state IDLE, round-robin pointer 0, err 0, all outputs 0. Any in-flight transaction is discarded with no ack. Reset overrides everything else.
- Valid requester: req[i]=1 and req_op[i]!=00.
- IDLE: if any valid requester exists, pick the first valid index at or after the pointer, wrapping. Latch index, op, addr and req_wb into the transaction registers, then set pointer = (winner+1) mod N_CPU.
  - Next state is VICTIM_WB if req_wb is set, else BCAST.
- VICTIM_WB: mem_req=1, mem_we=1, mem_addr=latched addr. When mem_ready=1, go to BCAST.
- BCAST: bus_valid=1 for exactly one cycle; bus_op, bus_addr, bus_src driven from the latched values. Go to SNOOP.
- SNOOP: sample snoop_wb with the requester's own bit masked.
  - Any remaining bit set: go to OWNER_WB.
  - Else, op=invalidate: go to DONE.
  - Else: go to FILL.
- OWNER_WB: mem_req=1, mem_we=1. When mem_ready=1: go to DONE if op=invalidate, else FILL.
- FILL: mem_req=1, mem_we=0. When mem_ready=1, go to DONE.
- DONE: ack[winner]=1 for one cycle, then return to IDLE.
- Requester rule: a requester drops req at the edge where it sees ack. That keeps it from being re-granted in the following IDLE cycle.
- Minimum latency, with req high in IDLE at cycle 0:
  - Invalidate: BCAST at cycle 1, SNOOP at 2, ack at 3.
  - Miss with mem_ready tied high: ack at 4.
  - Each write-back adds at least one cycle.
- Changes to req, req_op or req_addr after the grant are ignored. A requester dropping req mid-transaction does not abort it; ack still pulses.
- err is set, and stays set until reset, when:
  - more than one unmasked snoop_wb bit is high in SNOOP; the lowest index is serviced;
  - op=invalidate arrives with an unmasked snoop_wb bit; the owner write-back is still performed.
- mem_ready is ignored outside VICTIM_WB, OWNER_WB and FILL.
- mem_addr=0 whenever mem_req=0.
- Bus and memory outputs are driven from registered state. No combinational path from inputs to bus_* or ack.

Decomposition:
- Package msi_pkg holds:
  - cache state codes: INVALID 2'b00, SHARED 2'b01, MODIFIED 2'b10;
  - bus op codes: OP_NONE 00, OP_RDMISS 01, OP_WRMISS 10, OP_INV 11;
  - FSM state encoding: IDLE, VICTIM_WB, BCAST, SNOOP, OWNER_WB, FILL, DONE.
- One sub-module, rr_arbiter, parameterised by N_CPU. It takes the valid vector and pointer and returns a one-hot grant plus the encoded index. It is purely combinational; the pointer register lives in msi_bus_controller.

Test Plan:
- Invalidate: after reset, CPU1 req, op=11, addr=0x2A, no snoop_wb -> bus_valid at cycle 1 with bus_op=11, bus_addr=0x2A, bus_src=1; ack[1] at cycle 3; no mem_req.
- Read miss with owner: CPU0 op=01, addr=0x10; snoop_wb[3]=1 in SNOOP; mem_ready=1 -> mem write to 0x10, then mem read of 0x10, ack[0] at cycle 5; err stays 0.
- Victim write-back with slow memory: CPU2 op=10, req_wb=1; mem_ready delayed 3 cycles per access -> VICTIM_WB holds mem_req/mem_we=1 for 4 cycles; BCAST follows; ack[2] after FILL completes.
- Round-robin fairness: all four CPUs requesting continuously, each dropping req on ack and re-raising it next cycle -> grant order 0,1,2,3,0; no CPU granted twice before the others.
- Error and masking: CPU0 readMiss with snoop_wb=4'b0110 -> err=1, owner write-back serviced for CPU1 only. Self-bit snoop_wb[0]=1 on its own transaction -> ignored.
- Reset mid-transaction: reset asserted while in FILL -> next cycle busy=0, mem_req=0, no ack. Next grant goes to CPU0 because the pointer is 0.
